branch_redirect_ctrl: RTL and testbench
=======================================

Name: branch_redirect_ctrl

Overview:
- Sequences the front end after a branch or jump resolves in the execute stage.
- The branch unit's taken flag, target address and a resolve strobe arrive together. This block then:
  - redirects the PC, waiting for the fetch unit to accept;
  - flushes the wrong-path IF/ID and ID/EX stages for a fixed number of cycles;
  - stalls upstream while the redirect is pending.
- It also keeps saturating branch and taken-branch statistics counters.

Parameters:
- ADDR_WIDTH, 32: width of target and redirect addresses.
- FLUSH_CYCLES, 2: total cycles flush_o is asserted per taken branch, excluding fetch wait cycles. Legal range 1..15.
- CNT_WIDTH, 16: width of the statistics counters.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- branch_valid_i, input, 1: one-cycle strobe; a branch or jump resolved this cycle.
- branch_taken_i, input, 1: branch flag from the branch unit. Qualified by branch_valid_i.
- target_addr_i, input, ADDR_WIDTH: resolved target. Qualified by branch_valid_i.
- fetch_ready_i, input, 1: fetch unit accepts a PC redirect this cycle.
- clear_stats_i, input, 1: synchronous clear of both counters.
- pc_sel_o, output, 1: 1 selects redirect_addr_o as the next PC.
- pc_write_o, output, 1: one-cycle pulse; PC loads redirect_addr_o this cycle.
- redirect_addr_o, output, ADDR_WIDTH: latched target with bit 0 forced to 0.
- flush_o, output, 1: squash IF/ID and ID/EX contents.
- stall_o, output, 1: hold PC and IF/ID; redirect pending, fetch not ready.
- busy_o, output, 1: controller not in IDLE.
- branch_count_o, output, CNT_WIDTH: branches resolved, taken or not.
- taken_count_o, output, CNT_WIDTH: taken branches and jumps.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, flush counter=0, redirect_addr_o=0, both statistics counters=0.
  - All single-bit outputs 0.
  - Reset mid-sequence abandons the redirect immediately.
- State machine, 3 states. Outputs are combinational from state and registers.
- IDLE:
  - All control outputs 0.
  - On branch_valid_i=1 and branch_taken_i=1: latch {target_addr_i[ADDR_WIDTH-1:1],0} into redirect_addr_o; next state REDIRECT.
  - On branch_valid_i=1 and branch_taken_i=0: count only, stay in IDLE.
- REDIRECT:
  - pc_sel_o=1, flush_o=1, busy_o=1, stall_o=~fetch_ready_i.
  - If fetch_ready_i=1: pc_write_o=1. Then if FLUSH_CYCLES=1, go to IDLE. Otherwise load flush counter with FLUSH_CYCLES-2 and go to FLUSH.
  - If fetch_ready_i=0: stay in REDIRECT; no wait limit.
- FLUSH:
  - flush_o=1, busy_o=1; pc_sel_o=0, pc_write_o=0, stall_o=0.
  - If counter=0, go to IDLE; else decrement.
  - FLUSH lasts FLUSH_CYCLES-1 cycles.
- Latency:
  - Strobe at cycle T gives REDIRECT at T+1.
  - With fetch ready, pc_write_o is at T+1.
  - flush_o is high from T+1 through T+FLUSH_CYCLES.
  - IDLE again at T+FLUSH_CYCLES+1.
- Wrong-path suppression:
  - branch_valid_i in REDIRECT or FLUSH is ignored entirely: no state change, no latch, no count.
- A new taken strobe in the first IDLE cycle after FLUSH is accepted normally (back-to-back).
- Counters:
  - branch_count_o +1 per accepted strobe (IDLE only).
  - taken_count_o +1 per accepted taken strobe.
  - Both saturate at all-ones and do not wrap.
  - clear_stats_i=1 zeroes both next edge and has priority over a same-cycle increment.
  - The clear does not affect the state machine.
- redirect_addr_o holds its value outside REDIRECT until the next accepted taken strobe.
- X on branch_taken_i or target_addr_i is ignored when branch_valid_i=0.

Test Plan:
- Taken redirect, fetch always ready, FLUSH_CYCLES=2:
  - Stimulus: strobe taken, target 0x0000_0104 at T.
  - Required: pc_sel_o=1, pc_write_o=1 at T+1; flush_o=1 at T+1 and T+2; busy_o=0 at T+3; redirect_addr_o=0x104; counts 1/1.
- Fetch stall:
  - Stimulus: taken strobe, target 0x0000_2001; fetch_ready_i=0 for 3 cycles.
  - Required: stall_o=1, pc_sel_o=1, pc_write_o=0 for T+1..T+3. At T+4: pc_write_o=1, redirect_addr_o=0x2000. flush_o stays high through T+5.
- Not-taken strobe:
  - Stimulus: strobe with branch_taken_i=0.
  - Required: all control outputs stay 0; branch_count_o=1, taken_count_o=0.
- Wrong-path strobes:
  - Stimulus: taken strobe at T; further taken strobes at T+1 and T+2.
  - Required: ignored; redirect_addr_o unchanged; counts 1/1. A strobe at T+3 (IDLE) is accepted.
- Saturation and clear, CNT_WIDTH=4:
  - Stimulus: 17 taken strobes, spaced out; then clear_stats_i together with a strobe.
  - Required: counts saturate at 15/15 after the 17 strobes; after the clear, both 0.
- Async reset:
  - Stimulus: reset low mid-REDIRECT, between clock edges.
  - Required: flush_o, pc_sel_o, busy_o drop to 0 immediately; counters 0; no pc_write_o after release.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
// Front-end redirect sequencer: after a taken branch resolves, steers the PC to the
// latched target, squashes wrong-path stages for a fixed window and keeps branch statistics.
module branch_redirect_ctrl #(
    parameter int ADDR_WIDTH   = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  branch_valid_i,
    input  logic                  branch_taken_i,
    input  logic [ADDR_WIDTH-1:0] target_addr_i,
    input  logic                  fetch_ready_i,
    input  logic                  clear_stats_i,
    output logic                  pc_sel_o,
    output logic                  pc_write_o,
    output logic [ADDR_WIDTH-1:0] redirect_addr_o,
    output logic                  flush_o,
    output logic                  stall_o,
    output logic                  busy_o,
    output logic [CNT_WIDTH-1:0]  branch_count_o,
    output logic [CNT_WIDTH-1:0]  taken_count_o
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] REDIRECT = 2'd1;
    localparam logic [1:0] FLUSH    = 2'd2;

    // The redirect cycle itself is the first flush cycle, so the counter covers the rest.
    localparam logic [3:0] FLUSH_LOAD = 4'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [1:0]            state_reg, state_next;
    logic [3:0]            flush_cnt_reg, flush_cnt_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [CNT_WIDTH-1:0]  branch_cnt_reg, branch_cnt_next;
    logic [CNT_WIDTH-1:0]  taken_cnt_reg, taken_cnt_next;
    logic                  accept;

    // Strobes outside IDLE come from wrong-path instructions and are dropped entirely.
    assign accept = (state_reg == IDLE) && branch_valid_i;

    always_comb begin
        state_next     = state_reg;
        flush_cnt_next = flush_cnt_reg;
        addr_next      = addr_reg;
        case (state_reg)
            IDLE: begin
                if (branch_valid_i && branch_taken_i) begin
                    addr_next  = {target_addr_i[ADDR_WIDTH-1:1], 1'b0};
                    state_next = REDIRECT;
                end
            end
            REDIRECT: begin
                if (fetch_ready_i) begin
                    if (FLUSH_CYCLES == 1) begin
                        state_next = IDLE;
                    end else begin
                        flush_cnt_next = FLUSH_LOAD;
                        state_next     = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (flush_cnt_reg == 4'd0) begin
                    state_next = IDLE;
                end else begin
                    flush_cnt_next = flush_cnt_reg - 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        branch_cnt_next = branch_cnt_reg;
        taken_cnt_next  = taken_cnt_reg;
        if (clear_stats_i) begin
            branch_cnt_next = '0;
            taken_cnt_next  = '0;
        end else if (accept) begin
            if (!(&branch_cnt_reg)) begin
                branch_cnt_next = branch_cnt_reg + CNT_ONE;
            end
            if (branch_taken_i && !(&taken_cnt_reg)) begin
                taken_cnt_next = taken_cnt_reg + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            flush_cnt_reg  <= 4'd0;
            addr_reg       <= '0;
            branch_cnt_reg <= '0;
            taken_cnt_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            flush_cnt_reg  <= flush_cnt_next;
            addr_reg       <= addr_next;
            branch_cnt_reg <= branch_cnt_next;
            taken_cnt_reg  <= taken_cnt_next;
        end
    end

    assign pc_sel_o        = (state_reg == REDIRECT);
    assign pc_write_o      = (state_reg == REDIRECT) && fetch_ready_i;
    assign stall_o         = (state_reg == REDIRECT) && !fetch_ready_i;
    assign flush_o         = (state_reg == REDIRECT) || (state_reg == FLUSH);
    assign busy_o          = (state_reg != IDLE);
    assign redirect_addr_o = addr_reg;
    assign branch_count_o  = branch_cnt_reg;
    assign taken_count_o   = taken_cnt_reg;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Randomized bench for branch_redirect_ctrl: an abstract cycle model checks every output,
// and a scoreboard matches each PC write against the target queued at acceptance.
module tb_branch_redirect_ctrl;

    localparam int AW   = 32;
    localparam int FC   = 2;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          reset;
    logic          branch_valid_i;
    logic          branch_taken_i;
    logic [AW-1:0] target_addr_i;
    logic          fetch_ready_i;
    logic          clear_stats_i;
    logic          pc_sel_o;
    logic          pc_write_o;
    logic [AW-1:0] redirect_addr_o;
    logic          flush_o;
    logic          stall_o;
    logic          busy_o;
    logic [CW-1:0] branch_count_o;
    logic [CW-1:0] taken_count_o;

    branch_redirect_ctrl #(
        .ADDR_WIDTH   (AW),
        .FLUSH_CYCLES (FC),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .branch_valid_i  (branch_valid_i),
        .branch_taken_i  (branch_taken_i),
        .target_addr_i   (target_addr_i),
        .fetch_ready_i   (fetch_ready_i),
        .clear_stats_i   (clear_stats_i),
        .pc_sel_o        (pc_sel_o),
        .pc_write_o      (pc_write_o),
        .redirect_addr_o (redirect_addr_o),
        .flush_o         (flush_o),
        .stall_o         (stall_o),
        .busy_o          (busy_o),
        .branch_count_o  (branch_count_o),
        .taken_count_o   (taken_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] mon_exp;

    // Reference model: a pending-redirect flag plus the number of flush cycles still owed.
    bit            m_pend;
    int            m_flush_left;
    bit            m_idle;
    logic [AW-1:0] m_addr;
    int            m_bc;
    int            m_tc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            m_pend       = 1'b0;
            m_flush_left = 0;
            m_addr       = '0;
            m_bc         = 0;
            m_tc         = 0;
            exp_q.delete();
            chk("rst_pc_sel", pc_sel_o, 0);
            chk("rst_pc_write", pc_write_o, 0);
            chk("rst_stall", stall_o, 0);
            chk("rst_flush", flush_o, 0);
            chk("rst_busy", busy_o, 0);
            chk("rst_addr", redirect_addr_o, 0);
            chk("rst_branch_count", branch_count_o, 0);
            chk("rst_taken_count", taken_count_o, 0);
        end else begin
            m_idle = !m_pend && (m_flush_left == 0);
            chk("pc_sel", pc_sel_o, m_pend);
            chk("pc_write", pc_write_o, m_pend && fetch_ready_i);
            chk("stall", stall_o, m_pend && !fetch_ready_i);
            chk("flush", flush_o, !m_idle);
            chk("busy", busy_o, !m_idle);
            chk("redirect_addr", redirect_addr_o, m_addr);
            chk("branch_count", branch_count_o, m_bc);
            chk("taken_count", taken_count_o, m_tc);

            if (m_pend && fetch_ready_i) begin
                m_pend       = 1'b0;
                m_flush_left = FC - 1;
            end else if (!m_pend && m_flush_left > 0) begin
                m_flush_left--;
            end

            if (m_idle && branch_valid_i) begin
                m_bc = (m_bc + 1 > CMAX) ? CMAX : m_bc + 1;
                if (branch_taken_i) begin
                    m_tc   = (m_tc + 1 > CMAX) ? CMAX : m_tc + 1;
                    m_pend = 1'b1;
                    m_addr = target_addr_i & ~32'd1;
                    exp_q.push_back(m_addr);
                    $display("[TB] %0t accept taken target=%h", $time, target_addr_i);
                end else begin
                    $display("[TB] %0t accept not-taken", $time);
                end
            end
            if (clear_stats_i) begin
                m_bc = 0;
                m_tc = 0;
            end
        end
    end

    // Scoreboard monitor: every PC write must consume the oldest accepted target.
    always @(negedge clk) begin
        if (reset && pc_write_o) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pc_write: got addr %h, expected no write at %0t",
                         redirect_addr_o, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("redirect_target", redirect_addr_o, mon_exp);
                $display("[TB] %0t pc_write addr=%h", $time, redirect_addr_o);
            end
        end
    end

    task automatic drive(input bit v, input bit t, input logic [AW-1:0] a,
                         input bit fr, input bit clr);
        @(posedge clk);
        #1;
        branch_valid_i = v;
        branch_taken_i = t;
        target_addr_i  = a;
        fetch_ready_i  = fr;
        clear_stats_i  = clr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, $urandom, 1, 0);
    endtask

    initial begin
        reset          = 1'b0;
        branch_valid_i = 1'b0;
        branch_taken_i = 1'b0;
        target_addr_i  = '0;
        fetch_ready_i  = 1'b1;
        clear_stats_i  = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Basic taken redirect
        idle(2);
        drive(1, 1, 32'h0000_0104, 1, 0);
        idle(4);

        // Fetch stall for three cycles, odd target
        drive(1, 1, 32'h0000_2001, 1, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 32'h0, 0, 0);
        idle(4);

        // Not-taken strobe
        drive(1, 0, 32'hDEAD_BEEF, 1, 0);
        idle(2);

        // Wrong-path strobes then back-to-back accept
        drive(1, 1, 32'h0000_0300, 1, 0);
        drive(1, 1, 32'h0000_0400, 1, 0);
        drive(1, 1, 32'h0000_0500, 1, 0);
        drive(1, 1, 32'h0000_0600, 1, 0);
        idle(4);

        // Saturation, then clear together with a strobe
        for (int i = 0; i < 17; i++) begin
            drive(1, 1, 32'h1000 + 32'(i * 8), 1, 0);
            idle(3);
        end
        drive(1, 1, 32'h0000_7777, 1, 1);
        idle(4);

        // Asynchronous reset while REDIRECT waits on fetch
        drive(1, 1, 32'h0000_ABCD, 0, 0);
        drive(0, 0, 32'h0, 0, 0);
        #2 reset = 1'b0;
        #1;
        chk("async_flush", flush_o, 0);
        chk("async_pc_sel", pc_sel_o, 0);
        chk("async_busy", busy_o, 0);
        chk("async_branch_count", branch_count_o, 0);
        chk("async_taken_count", taken_count_o, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        fetch_ready_i = 1'b1;
        idle(4);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 6, $urandom,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
        end
        idle(8);

        chk("queue_drained", 64'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
